// File: rtl/power_seq_pkg.sv
// Shared types for the power-domain sequencer: FSM state encoding and the
// bundle of domain-control outputs with their fully-on / fully-off values.
package power_seq_pkg;

  typedef enum logic [3:0] {
    ST_ON,
    ST_CLK_GATE,
    ST_ISO_SET,
    ST_RST_SET,
    ST_SW_OFF,
    ST_OFF,
    ST_SW_ON,
    ST_RST_REL,
    ST_ISO_REL,
    ST_CLK_UNGATE
  } pwr_seq_state_e;

  typedef struct packed {
    logic switch_n;
    logic iso;
    logic rst_n;
    logic clk_en;
  } pwr_seq_outs_t;

  localparam pwr_seq_outs_t ON_OUTS  = '{switch_n: 1'b0, iso: 1'b0, rst_n: 1'b1, clk_en: 1'b1};
  localparam pwr_seq_outs_t OFF_OUTS = '{switch_n: 1'b1, iso: 1'b1, rst_n: 1'b0, clk_en: 1'b0};

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/power_seq_ack_sync.sv
// Two-flop synchronizer for the power-switch acknowledge; the reset value
// matches the switch level implied by the domain's post-reset state.
module power_seq_ack_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/power_domain_sequencer.sv
// Power-gate sequencer for one domain: orders clock gating, isolation, domain
// reset and the switch handshake on the way down and back up.
module power_domain_sequencer
  import power_seq_pkg::*;
#(
  parameter bit RESET_ON        = 1'b1,
  parameter int CLK_GATE_CYCLES = 2,
  parameter int ISO_CYCLES      = 2,
  parameter int RST_CYCLES      = 2,
  parameter int ACK_TIMEOUT     = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pwr_off_req_i,
  input  logic pwr_on_req_i,
  input  logic switch_ack_n_i,
  input  logic err_clear_i,
  output logic switch_n_o,
  output logic iso_en_o,
  output logic rst_domain_n_o,
  output logic clk_en_o,
  output logic powered_o,
  output logic busy_o,
  output logic timeout_o
);

  localparam int CNT_W  = $clog2(max3(CLK_GATE_CYCLES, ISO_CYCLES, RST_CYCLES)) + 1;
  localparam int WAIT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  localparam logic [CNT_W-1:0]  CG_LOAD    = CNT_W'(CLK_GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  ISO_LOAD   = CNT_W'(ISO_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RST_LOAD   = CNT_W'(RST_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(ACK_TIMEOUT);

  localparam pwr_seq_state_e RST_STATE = RESET_ON ? ST_ON : ST_OFF;
  localparam pwr_seq_outs_t  RST_OUTS  = RESET_ON ? ON_OUTS : OFF_OUTS;

  pwr_seq_state_e    state_q, state_d;
  pwr_seq_outs_t     outs_q, outs_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WAIT_W-1:0] wait_inc;
  logic              timeout_q, timeout_d;
  logic              powered_q, powered_d;
  logic              busy_q, busy_d;
  logic              ack_s;
  logic              in_wait;
  logic              ack_done;

  power_seq_ack_sync #(
    .RESET_VAL(RESET_ON ? 1'b0 : 1'b1)
  ) u_ack_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (switch_ack_n_i),
    .q_o   (ack_s)
  );

  assign in_wait  = (state_q == ST_SW_OFF) || (state_q == ST_SW_ON);
  assign ack_done = ((state_q == ST_SW_OFF) && ack_s) || ((state_q == ST_SW_ON) && !ack_s);
  assign wait_inc = wait_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    outs_d    = outs_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    timeout_d = timeout_q & ~err_clear_i;

    case (state_q)
      ST_ON: begin
        if (pwr_off_req_i) begin
          state_d       = ST_CLK_GATE;
          outs_d.clk_en = 1'b0;
          cnt_d         = CG_LOAD;
        end
      end
      ST_CLK_GATE: begin
        if (cnt_q == '0) begin
          state_d    = ST_ISO_SET;
          outs_d.iso = 1'b1;
          cnt_d      = ISO_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ISO_SET: begin
        if (cnt_q == '0) begin
          state_d      = ST_RST_SET;
          outs_d.rst_n = 1'b0;
          cnt_d        = RST_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RST_SET: begin
        if (cnt_q == '0) begin
          state_d         = ST_SW_OFF;
          outs_d.switch_n = 1'b1;
          wait_d          = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SW_OFF: begin
        if (ack_done) state_d = ST_OFF;
      end
      ST_OFF: begin
        if (pwr_on_req_i) begin
          state_d         = ST_SW_ON;
          outs_d.switch_n = 1'b0;
          wait_d          = '0;
        end
      end
      ST_SW_ON: begin
        if (ack_done) begin
          state_d      = ST_RST_REL;
          outs_d.rst_n = 1'b1;
          cnt_d        = RST_LOAD;
        end
      end
      ST_RST_REL: begin
        if (cnt_q == '0) begin
          state_d    = ST_ISO_REL;
          outs_d.iso = 1'b0;
          cnt_d      = ISO_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ISO_REL: begin
        if (cnt_q == '0) begin
          state_d       = ST_CLK_UNGATE;
          outs_d.clk_en = 1'b1;
          cnt_d         = CG_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_CLK_UNGATE: begin
        if (cnt_q == '0) begin
          state_d = ST_ON;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = RST_STATE;
        outs_d  = RST_OUTS;
      end
    endcase

    // Keep waiting after a timeout; the counter saturates so the flag fires once.
    if (in_wait && !ack_done && (ACK_TIMEOUT != 0) && (wait_q != WAIT_LIMIT)) begin
      wait_d = wait_inc;
      if (wait_inc == WAIT_LIMIT) timeout_d = 1'b1;
    end

    powered_d = (state_d == ST_ON);
    busy_d    = (state_d != ST_ON) && (state_d != ST_OFF);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RST_STATE;
      outs_q    <= RST_OUTS;
      cnt_q     <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      powered_q <= RESET_ON;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      outs_q    <= outs_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      powered_q <= powered_d;
      busy_q    <= busy_d;
    end
  end

  assign switch_n_o     = outs_q.switch_n;
  assign iso_en_o       = outs_q.iso;
  assign rst_domain_n_o = outs_q.rst_n;
  assign clk_en_o       = outs_q.clk_en;
  assign powered_o      = powered_q;
  assign busy_o         = busy_q;
  assign timeout_o      = timeout_q;

endmodule
